// File: rtl/round_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : round_controller_if
// Description : Keyboard/game-event inputs and screen/sprite outputs of the
//               rhythm-game round controller, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface round_controller_if #(
   parameter int CW = 3
);
   logic [7:0]    keycode;
   logic          hit;
   logic          out_of_bounds;
   logic [3:0]    health;
   logic          main;
   logic          playbackground;
   logic          fail;
   logic          success;
   logic          spawn;
   logic [1:0]    circletype;
   logic [CW-1:0] round_cnt;
   logic [CW-1:0] hit_cnt;

   // Game environment side: keyboard path and circle sprite logic
   modport master (
      output keycode, hit, out_of_bounds, health,
      input  main, playbackground, fail, success, spawn, circletype,
             round_cnt, hit_cnt
   );

   // Controller side
   modport slave (
      input  keycode, hit, out_of_bounds, health,
      output main, playbackground, fail, success, spawn, circletype,
             round_cnt, hit_cnt
   );
endinterface
`default_nettype wire

// File: rtl/round_controller.sv
`default_nettype none
// ============================================================================
// Module      : round_controller
// Description : Game sequencer: main screen, NUM_ROUNDS circle spawns with
//               hit/miss tallying, per-circle timeout, health fail and
//               pass/fail screens. Held keys must be released to re-arm.
// Revision    : 1.0 - initial release
// ============================================================================
module round_controller #(
   parameter int NUM_ROUNDS     = 5,
   parameter int PASS_HITS      = 2,
   parameter int TIMEOUT_CYCLES = 600,
   parameter int CW             = $clog2(NUM_ROUNDS + 1)
) (
   input  logic              Clk,
   input  logic              Reset_n,
   round_controller_if.slave bus
);

   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_QUIT  = 8'h14;
   localparam logic [7:0] KEY_Z     = 8'h1D;
   localparam logic [7:0] KEY_X     = 8'h1B;
   localparam logic [7:0] KEY_C     = 8'h06;
   localparam logic [7:0] KEY_V     = 8'h19;

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_MAIN     = 3'd0,
      S_PLAY     = 3'd1,
      S_SPAWN    = 3'd2,
      S_ACTIVE   = 3'd3,
      S_TALLY    = 3'd4,
      S_FINISHED = 3'd5,
      S_FAIL     = 3'd6,
      S_PASS     = 3'd7
   } state_t;

   state_t        state, state_nxt;
   logic          armed;
   logic          hit_flag;
   logic [1:0]    type_reg;
   logic [TW-1:0] tmo_cnt;
   logic [CW-1:0] round_cnt, hit_cnt;

   logic          key_taken;
   logic          clr_cnt;
   logic          latch_type;
   logic          tmo_inc;
   logic          is_spawn_key;
   logic [1:0]    key_type;

   // Decode the spawn keys into a circle type
   always_comb begin
      is_spawn_key = 1'b1;
      key_type     = 2'b00;
      case (bus.keycode)
         KEY_Z:   key_type = 2'b00;
         KEY_X:   key_type = 2'b01;
         KEY_C:   key_type = 2'b10;
         KEY_V:   key_type = 2'b11;
         default: is_spawn_key = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= S_MAIN;
      else          state <= state_nxt;
   end

   // Next-state logic and datapath control strobes
   always_comb begin
      state_nxt  = state;
      key_taken  = 1'b0;
      clr_cnt    = 1'b0;
      latch_type = 1'b0;
      tmo_inc    = 1'b0;
      case (state)
         S_MAIN: begin
            if (armed && bus.keycode == KEY_SPACE) begin
               state_nxt = S_PLAY;
               key_taken = 1'b1;
               clr_cnt   = 1'b1;
            end
         end
         S_PLAY: begin
            if (bus.keycode == KEY_QUIT) begin
               state_nxt = S_FAIL;
               key_taken = 1'b1;
            end else if (bus.health == 4'd0) begin
               state_nxt = S_FAIL;
            end else if (round_cnt == CW'(NUM_ROUNDS)) begin
               state_nxt = S_FINISHED;
            end else if (armed && is_spawn_key) begin
               state_nxt  = S_SPAWN;
               key_taken  = 1'b1;
               latch_type = 1'b1;
            end
         end
         S_SPAWN: state_nxt = S_ACTIVE;
         S_ACTIVE: begin
            if (bus.keycode == KEY_QUIT || bus.health == 4'd0) begin
               state_nxt = S_FAIL;
               key_taken = (bus.keycode == KEY_QUIT);
            end else if (bus.hit || bus.out_of_bounds ||
                         tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = S_TALLY;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         S_TALLY: state_nxt = S_PLAY;
         S_FINISHED: begin
            if (int'(hit_cnt) >= PASS_HITS) state_nxt = S_PASS;
            else                            state_nxt = S_FAIL;
         end
         S_FAIL, S_PASS: begin
            if (armed && bus.keycode == KEY_SPACE) begin
               state_nxt = S_MAIN;
               key_taken = 1'b1;
            end
         end
         default: state_nxt = S_MAIN;
      endcase
   end

   // Re-arm: a released keyboard arms, a consumed key disarms
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                  armed <= 1'b0;
      else if (key_taken)            armed <= 1'b0;
      else if (bus.keycode == 8'h00) armed <= 1'b1;
   end

   // Circle type latch and per-circle timeout counter
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         type_reg <= 2'b00;
         tmo_cnt  <= '0;
         hit_flag <= 1'b0;
      end else begin
         if (latch_type)           type_reg <= key_type;
         if (state == S_SPAWN)     tmo_cnt  <= '0;
         else if (tmo_inc)         tmo_cnt  <= tmo_cnt + TW'(1);
         // hit wins over out_of_bounds: only the exit cycle's value survives
         if (state == S_ACTIVE)    hit_flag <= bus.hit;
      end
   end

   // Round and hit counters; only TALLY advances them
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         round_cnt <= '0;
         hit_cnt   <= '0;
      end else if (clr_cnt) begin
         round_cnt <= '0;
         hit_cnt   <= '0;
      end else if (state == S_TALLY) begin
         round_cnt <= round_cnt + CW'(1);
         if (hit_flag) hit_cnt <= hit_cnt + CW'(1);
      end
   end

   // Moore output decode
   always_comb begin
      bus.main           = 1'b0;
      bus.playbackground = 1'b0;
      bus.fail           = 1'b0;
      bus.success        = 1'b0;
      bus.spawn          = 1'b0;
      bus.circletype     = 2'b00;
      case (state)
         S_MAIN:   bus.main = 1'b1;
         S_SPAWN: begin
            bus.playbackground = 1'b1;
            bus.spawn          = 1'b1;
            bus.circletype     = type_reg;
         end
         S_ACTIVE: begin
            bus.playbackground = 1'b1;
            bus.circletype     = type_reg;
         end
         S_PLAY, S_TALLY, S_FINISHED: bus.playbackground = 1'b1;
         S_FAIL:   bus.fail    = 1'b1;
         S_PASS:   bus.success = 1'b1;
         default:  bus.main    = 1'b1;
      endcase
   end

   assign bus.round_cnt = round_cnt;
   assign bus.hit_cnt   = hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_controller
// Description : Self-checking bench for round_controller: scripted and
//               randomized games scored against an arithmetic game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_controller;

   localparam int NR = 5;
   localparam int PH = 2;
   localparam int TO = 8;
   localparam int CW = $clog2(NR + 1);

   localparam logic [7:0] K_SPACE = 8'h2C;
   localparam logic [7:0] K_QUIT  = 8'h14;
   localparam logic [7:0] K_Z     = 8'h1D;
   localparam logic [7:0] K_X     = 8'h1B;
   localparam logic [7:0] K_C     = 8'h06;
   localparam logic [7:0] K_V     = 8'h19;

   // screen code {main, playbackground, fail, success}
   localparam logic [3:0] SCR_MAIN = 4'b1000;
   localparam logic [3:0] SCR_PLAY = 4'b0100;
   localparam logic [3:0] SCR_FAIL = 4'b0010;
   localparam logic [3:0] SCR_PASS = 4'b0001;

   // responses to a live circle
   localparam int R_HIT = 0, R_OOB = 1, R_BOTH = 2, R_TMO = 3;

   logic Clk = 1'b0;
   logic Reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_round;
   int   exp_hits;

   round_controller_if #(.CW(CW)) bus ();

   round_controller #(
      .NUM_ROUNDS     (NR),
      .PASS_HITS      (PH),
      .TIMEOUT_CYCLES (TO),
      .CW             (CW)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] screen();
      return {bus.main, bus.playbackground, bus.fail, bus.success};
   endfunction

   function automatic logic [1:0] key_type(input logic [7:0] k);
      case (k)
         K_X:     return 2'b01;
         K_C:     return 2'b10;
         K_V:     return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // release keys, then a fresh SPACE press; expect a given screen after it
   task automatic press_space(input logic [3:0] exp_scr, input string tag);
      bus.keycode = 8'h00;
      tick();
      bus.keycode = K_SPACE;
      tick();
      check(tag, screen(), exp_scr);
      bus.keycode = 8'h00;
   endtask

   task automatic start_game();
      press_space(SCR_PLAY, "start_play");
      exp_round = 0;
      exp_hits  = 0;
      check("start_round_cnt", bus.round_cnt, 0);
      check("start_hit_cnt", bus.hit_cnt, 0);
      // SPACE still held in PLAY must change nothing
      bus.keycode = K_SPACE;
      repeat (3) tick();
      check("space_held_play", {screen(), bus.spawn}, {SCR_PLAY, 1'b0});
      bus.keycode = 8'h00;
      tick();
   endtask

   task automatic play_round(input logic [7:0] key, input int resp, input int delay);
      int cyc;
      bus.keycode = 8'h00;
      tick();
      bus.keycode = key;
      tick();
      check("spawn_pulse", bus.spawn, 1);
      check("spawn_type", bus.circletype, key_type(key));
      bus.keycode = ($urandom_range(1) == 1) ? key : 8'h00;
      tick();
      check("active_no_spawn", bus.spawn, 0);
      check("active_type", bus.circletype, key_type(key));
      if (resp == R_TMO) begin
         cyc = 1;
         while (bus.round_cnt == CW'(exp_round) && cyc < 40) begin
            tick();
            cyc++;
         end
         // TO cycles of ACTIVE, one TALLY, counters visible the cycle after
         check("timeout_len", cyc, TO + 2);
      end else begin
         repeat (delay) tick();
         bus.hit           = (resp != R_OOB);
         bus.out_of_bounds = (resp != R_HIT);
         tick();
         bus.hit           = 1'b0;
         bus.out_of_bounds = 1'b0;
         check("tally_not_yet", bus.round_cnt, exp_round);
         tick();
      end
      exp_round++;
      if (resp == R_HIT || resp == R_BOTH) exp_hits++;
      check("round_cnt", bus.round_cnt, exp_round);
      check("hit_cnt", bus.hit_cnt, exp_hits);
      check("play_screen", {screen(), bus.circletype}, {SCR_PLAY, 2'b00});
      bus.keycode = 8'h00;
   endtask

   task automatic finish_game();
      tick();
      check("finished_screen", screen(), SCR_PLAY);
      tick();
      check("result_screen", screen(), (exp_hits >= PH) ? SCR_PASS : SCR_FAIL);
      check("result_counts", {bus.round_cnt, bus.hit_cnt}, {CW'(exp_round), CW'(exp_hits)});
      press_space(SCR_MAIN, "back_to_main");
   endtask

   initial begin
      logic [7:0] keys [4];
      int         spawns;
      keys[0] = K_Z; keys[1] = K_X; keys[2] = K_C; keys[3] = K_V;

      bus.keycode       = K_SPACE;
      bus.hit           = 1'b0;
      bus.out_of_bounds = 1'b0;
      bus.health        = 4'd15;
      Reset_n           = 1'b0;
      repeat (3) tick();
      check("reset_screen", screen(), SCR_MAIN);
      check("reset_spawn", bus.spawn, 0);
      check("reset_type", bus.circletype, 0);
      check("reset_counts", {bus.round_cnt, bus.hit_cnt}, 0);
      Reset_n = 1'b1;
      repeat (5) tick();
      check("held_space_main", screen(), SCR_MAIN);

      // scripted: 2 hits -> PASS
      start_game();
      play_round(K_Z, R_HIT, 2);
      play_round(K_X, R_HIT, 0);
      play_round(K_C, R_OOB, 3);
      play_round(K_V, R_TMO, 0);
      play_round(K_Z, R_OOB, 1);
      finish_game();

      // scripted: 1 hit (hit+oob together) -> FAIL
      start_game();
      play_round(K_Z, R_BOTH, 1);
      play_round(K_X, R_TMO, 0);
      play_round(K_C, R_OOB, 0);
      play_round(K_V, R_OOB, 4);
      play_round(K_Z, R_TMO, 0);
      finish_game();

      // held Z gives a single spawn; then QUIT in ACTIVE
      start_game();
      bus.keycode = K_Z;
      spawns = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus.spawn) spawns++;
      end
      check("held_key_spawns", spawns, 1);
      check("held_key_round", {bus.round_cnt, bus.hit_cnt}, {CW'(1), CW'(0)});
      bus.keycode = 8'h00;
      tick();
      bus.keycode = K_X;
      tick();
      bus.keycode = 8'h00;
      tick();
      bus.keycode = K_QUIT;
      tick();
      check("quit_active", screen(), SCR_FAIL);
      press_space(SCR_MAIN, "quit_to_main");

      // health 0 in PLAY
      start_game();
      bus.health = 4'd0;
      tick();
      check("health_fail", screen(), SCR_FAIL);
      bus.health = 4'd9;
      press_space(SCR_MAIN, "health_to_main");

      // randomized games
      for (int g = 0; g < 6; g++) begin
         start_game();
         for (int r = 0; r < NR; r++)
            play_round(keys[$urandom_range(3)], int'($urandom_range(3)),
                       int'($urandom_range(TO - 2)));
         finish_game();
      end

      // asynchronous reset during ACTIVE
      start_game();
      play_round(K_V, R_HIT, 0);
      bus.keycode = 8'h00;
      tick();
      bus.keycode = K_C;
      tick();
      bus.keycode = 8'h00;
      tick();
      #2 Reset_n = 1'b0;
      #1;
      check("async_reset_screen", {screen(), bus.spawn}, {SCR_MAIN, 1'b0});
      check("async_reset_counts", {bus.round_cnt, bus.hit_cnt}, 0);
      tick();
      Reset_n = 1'b1;
      tick();
      check("after_reset_main", screen(), SCR_MAIN);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
